// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- frame-level controller for the UART receiver.
//
// Detects a start condition on RX_IN and runs the per-bit tick counter that
// drives the external majority-vote sampler. At the end of every bit it
// takes the sampler's Sampled_bit and uses it as the start check, a data
// bit (LSB first), the parity bit or the stop bit. The received byte is
// presented with a one-cycle valid strobe.
//
// Ports
//   Clk          oversampling clock, Prescale ticks per bit
//   Rst          asynchronous, active-low reset
//   RX_IN        serial line, idle high; used for start detection only
//   Prescale     oversampling ratio (even, 8..32), captured at frame start
//   PAR_EN       parity bit present, captured at frame start
//   PAR_TYP      0 = even, 1 = odd parity, captured at frame start
//   Sampled_bit  voted bit value from the data sampler
//   Edge_count   tick index within the current bit, drives the sampler
//   Bit_count    frame bit index: start=0, data=1..DATA_WIDTH, parity, stop
//   P_DATA       last good received byte
//   Data_valid   one-cycle pulse when P_DATA is updated
//   Par_err      one-cycle pulse at frame end on parity mismatch
//   Stp_err      one-cycle pulse at frame end when the stop bit is 0
//   Busy         high whenever a frame is in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for RX_IN low
// S_START  | inside the start bit; a high vote at its end is a glitch
// S_DATA   | shifting in DATA_WIDTH data bits, LSB first
// S_PARITY | checking the parity bit against the received data
// S_STOP   | checking the stop bit, then publishing the byte or flags

module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  Sampled_bit,
   output logic [PRESCALE_W-1:0] Edge_count,
   output logic [3:0]            Bit_count,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_valid,
   output logic                  Par_err,
   output logic                  Stp_err,
   output logic                  Busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

   state_t                 state;
   logic [PRESCALE_W-1:0]  pc;
   logic                   pe;
   logic                   pt;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic                   par_fail;
   logic                   eob;

   assign eob = (Edge_count == (pc - PRESCALE_W'(1)));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         pe         <= 1'b0;
         pt         <= 1'b0;
         shift_reg  <= '0;
         par_fail   <= 1'b0;
         Edge_count <= '0;
         Bit_count  <= '0;
         P_DATA     <= '0;
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stp_err    <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stp_err    <= 1'b0;

         if (state == S_IDLE) begin
            Edge_count <= '0;
            Bit_count  <= '0;
            if (!RX_IN) begin
               // The detecting edge counts as tick 0 of the start bit, so
               // bit k closes on the edge (k+1)*pc after detection.
               pc       <= Prescale;
               pe       <= PAR_EN;
               pt       <= PAR_TYP;
               par_fail <= 1'b0;
               state    <= S_START;
               Busy     <= 1'b1;
            end
         end else begin
            if (eob) begin
               Edge_count <= '0;
               Bit_count  <= Bit_count + 4'd1;
            end else begin
               Edge_count <= Edge_count + PRESCALE_W'(1);
            end

            if (eob) begin
               case (state)
                  S_START: begin
                     if (Sampled_bit) begin
                        state     <= S_IDLE;
                        Busy      <= 1'b0;
                        Bit_count <= '0;
                     end else begin
                        state <= S_DATA;
                     end
                  end
                  S_DATA: begin
                     shift_reg <= {Sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                     if (Bit_count == LAST_DATA)
                        state <= pe ? S_PARITY : S_STOP;
                  end
                  S_PARITY: begin
                     if (Sampled_bit != ((^shift_reg) ^ pt))
                        par_fail <= 1'b1;
                     state <= S_STOP;
                  end
                  S_STOP: begin
                     state     <= S_IDLE;
                     Busy      <= 1'b0;
                     Bit_count <= '0;
                     Par_err   <= par_fail;
                     Stp_err   <= ~Sampled_bit;
                     if (!par_fail && Sampled_bit) begin
                        P_DATA     <= shift_reg;
                        Data_valid <= 1'b1;
                     end
                  end
                  default: begin
                     state     <= S_IDLE;
                     Busy      <= 1'b0;
                     Bit_count <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule
